sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's fixed 8-bit FIFO.
- Generalised in data width and depth.
- Adds:
  - runtime-programmable almost-full/almost-empty thresholds
  - occupancy count output
  - sticky overflow/underflow flags with clear
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between producer/consumer blocks in a single clock domain; drop-in replacement for the existing FIFO when FWFT=0.

---
 rtl/fifo_defs_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 34 +++
 rtl/sync_fifo_param.sv | 127 ++++++++++++
 tb/tb_sync_fifo_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
// -----------------------------------------------------------------------------
// fifo_defs
// Shared definitions for the parametrised synchronous FIFO.
//   fifo_log2 : ceiling log2 used to derive address widths from a depth
//   FWFT_OFF  : standard registered read (1-cycle read latency)
//   FWFT_ON   : first-word-fall-through read (head word always on data_out)
// -----------------------------------------------------------------------------
package fifo_defs;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Smallest r such that 2**r >= value; returns 0 for value <= 1.
  function automatic int fifo_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage, DATA_W x DEPTH: synchronous write, asynchronous
// read. Contents are never reset.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable
//   i_waddr  write address (AW bits)
//   i_wdata  write data (DATA_W bits)
//   i_raddr  read address (AW bits)
//   o_rdata  combinational read data at i_raddr
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a
// selectable standard or first-word-fall-through read mode.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   wr_en, data_in      write request and data
//   rd_en, data_out     read request and data
//   af_thresh           almost_full  when count >= af_thresh
//   ae_thresh           almost_empty when count <= ae_thresh
//   err_clr             clears sticky overflow/underflow (a new set wins)
//   full, empty         count == DEPTH / count == 0
//   almost_full/_empty  threshold compares on registered count
//   count               occupancy 0..DEPTH
//   overflow/underflow  sticky rejected-write / rejected-read flags
//
// Handshake: wr_en and rd_en are requests; !full and !empty act as their
// ready. A write transfers on a rising edge when wr_en is high and the FIFO
// is not full, or is full but a read transfers on the same edge. A read
// transfers when rd_en is high and the FIFO is not empty. A request that does
// not transfer is dropped (never held over) and raises the sticky error flag.
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_defs::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = fifo_log2(DEPTH),
  parameter  int FWFT   = FWFT_OFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  input  logic [AW:0]       af_thresh,
  input  logic [AW:0]       ae_thresh,
  input  logic              err_clr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic [DATA_W-1:0] r_data_out;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rdata;

  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == '0);

  // A read frees a slot on the same edge, so a full FIFO still takes a write
  // alongside a read. An empty FIFO never takes a read, even with a write.
  assign w_rd_ok = rd_en && !w_empty;
  assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rdata;
      end

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Set has priority over clear so an error in the clearing cycle is kept.
      if (wr_en && !w_wr_ok) r_overflow <= 1'b1;
      else if (err_clr)      r_overflow <= 1'b0;

      if (rd_en && !w_rd_ok) r_underflow <= 1'b1;
      else if (err_clr)      r_underflow <= 1'b0;
    end
  end

  // In FWFT mode the head word is shown straight from the RAM; when empty the
  // value is stale and must be ignored by the consumer.
  assign data_out     = (FWFT == FWFT_ON) ? w_rdata : r_data_out;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [AW:0]   af_thresh = 5'd12;
  logic [AW:0]   ae_thresh = 5'd3;
  logic          err_clr = 1'b0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   s_count, f_count;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(s_dout), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(f_dout), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level view of one clock edge: a read takes the head, a write
  // appends, errors are remembered until cleared.
  task automatic model_edge();
    bit rd_ok, wr_ok;
    if (reset) begin
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_ok = rd_en && (exp_q.size() > 0);
      wr_ok = wr_en && ((exp_q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(data_in);
      if (wr_en && !wr_ok) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (rd_en && !rd_ok) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count",        32'(s_count), 32'(n));
    chk("count_fwft",   32'(f_count), 32'(n));
    chk("full",         32'(s_full),  32'(n == DEPTH));
    chk("empty",        32'(s_empty), 32'(n == 0));
    chk("almost_full",  32'(s_af),    32'(n >= int'(af_thresh)));
    chk("almost_empty", 32'(s_ae),    32'(n <= int'(ae_thresh)));
    chk("fwft_flags",   32'({f_full, f_empty, f_af, f_ae}), 32'({s_full, s_empty, s_af, s_ae}));
    chk("overflow",     32'(s_ovf),   32'(m_ovf));
    chk("underflow",    32'(s_unf),   32'(m_unf));
    chk("fwft_errs",    32'({f_ovf, f_unf}), 32'({m_ovf, m_unf}));
    chk("dout_std",     32'(s_dout),  32'(m_dout));
    if (n > 0) chk("dout_fwft", 32'(f_dout), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd,
                       input logic clr, input logic rst);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    err_clr = clr;
    reset   = rst;
    @(posedge clk);
    model_edge();
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; reset = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            exp_count;
    logic [DW-1:0] exp_dout;
    logic          exp_empty;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h33, 3, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h44, 4, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h55, 5, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 4, 8'h11, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 3, 8'h22, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 2, 8'h33, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 1, 8'h44, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 0, 8'h55, 1'b1};

    repeat (2) @(posedge clk);
    #1;

    // 1: write 0x11..0x55 then read them back
    do_reset();
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_dout",  32'(s_dout),  32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0, 1'b0);
      chk("t1_count", 32'(s_count), 32'(vecs[i].exp_count));
      chk("t1_dout",  32'(s_dout),  32'(vecs[i].exp_dout));
      chk("t1_empty", 32'(s_empty), 32'(vecs[i].exp_empty));
    end
    chk("t1_underflow", 32'(s_unf), 32'd0);

    // 2: fill, overflow, err_clr
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(DW'(8'h80 + i));
    chk("t2_full",  32'(s_full),  32'd1);
    chk("t2_count", 32'(s_count), 32'd16);
    push(8'hEE);
    chk("t2_ovf",   32'(s_ovf),   32'd1);
    chk("t2_count17", 32'(s_count), 32'd16);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t2_ovf_clr", 32'(s_ovf), 32'd0);

    // 3: simultaneous read/write at full, then drain
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(s_count), 32'd16);
    chk("t3_full",  32'(s_full),  32'd1);
    chk("t3_ovf",   32'(s_ovf),   32'd0);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("t3_last",  32'(s_dout),  32'hAA);

    // 4: underflow after drain, at reset, and write+read at empty
    pop();
    chk("t4_unf_drain", 32'(s_unf),  32'd1);
    chk("t4_dout_hold", 32'(s_dout), 32'hAA);
    do_reset();
    pop();
    chk("t4_unf_rst",   32'(s_unf),  32'd1);
    chk("t4_dout_rst",  32'(s_dout), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t4_wr_count",  32'(s_count), 32'd1);
    chk("t4_wr_unf",    32'(s_unf),   32'd1);
    chk("t4_fwft_head", 32'(f_dout),  32'h77);

    // 5: threshold walk 0 -> 16 -> 0, live threshold change at count 10
    do_reset();
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    for (int i = 0; i < 10; i++) push(DW'($urandom_range(0, 255)));
    chk("t5_af_before", 32'(s_af), 32'd0);
    af_thresh = 5'd8;
    #1;
    chk("t5_af_live", 32'(s_af), 32'd1);
    af_thresh = 5'd12;
    #1;
    for (int i = 0; i < 6; i++) push(DW'($urandom_range(0, 255)));
    for (int i = 0; i < DEPTH; i++) pop();
    // Degenerate thresholds force both almost flags.
    af_thresh = 5'd0;
    ae_thresh = 5'd16;
    push(8'h01);
    chk("t5_af0",  32'(s_af), 32'd1);
    chk("t5_ae16", 32'(s_ae), 32'd1);
    af_thresh = 5'd12;
    ae_thresh = 5'd3;

    // 6: FWFT fall-through and mid-stream reset
    do_reset();
    pop();
    push(8'h5A);
    chk("t6_fwft", 32'(f_dout), 32'h5A);
    for (int i = 0; i < 6; i++) push(DW'(i));
    chk("t6_count7", 32'(f_count), 32'd7);
    do_reset();
    chk("t6_rst_count", 32'(f_count), 32'd0);
    chk("t6_rst_empty", 32'(f_empty), 32'd1);
    chk("t6_rst_errs",  32'({f_ovf, f_unf}), 32'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        af_thresh = 5'($urandom_range(0, 17));
        ae_thresh = 5'($urandom_range(0, 17));
      end
      cycle(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
